// File: rtl/set_scan_pkg.sv
// Shared definitions for the set_scan front-end: field sizes, set-mode
// encodings, scan state encodings and the field offsets of central/radius.
package set_scan_pkg;

`ifndef COVERED_SZ
`define COVERED_SZ 3
`endif
`ifndef MODE_SZ
`define MODE_SZ 2
`endif
`ifndef MODE1
`define MODE1 2'd0
`endif
`ifndef MODE2
`define MODE2 2'd1
`endif
`ifndef MODE3
`define MODE3 2'd2
`endif
`ifndef MODE4
`define MODE4 2'd3
`endif

  localparam int COVERED_SZ = `COVERED_SZ;
  localparam int MODE_SZ    = `MODE_SZ;

  localparam logic [MODE_SZ-1:0] MODE1 = `MODE1;
  localparam logic [MODE_SZ-1:0] MODE2 = `MODE2;
  localparam logic [MODE_SZ-1:0] MODE3 = `MODE3;
  localparam logic [MODE_SZ-1:0] MODE4 = `MODE4;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_RUN,
    SCAN_DRAIN,
    SCAN_DONE
  } scan_state_t;

  // Field offsets in units of COORD_W; ports pack A first (MSB) and C last.
  localparam int CEN_AX = 5;
  localparam int CEN_AY = 4;
  localparam int CEN_BX = 3;
  localparam int CEN_BY = 2;
  localparam int CEN_CX = 1;
  localparam int CEN_CY = 0;
  localparam int RAD_A  = 2;
  localparam int RAD_B  = 1;
  localparam int RAD_C  = 0;

endpackage

// File: rtl/set_cover.sv
// Combinational point-in-circle test: (x-xc)^2 + (y-yc)^2 <= r^2, boundary inclusive.
module set_cover #(
  parameter int COORD_W = 4
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] xc,
  input  logic [COORD_W-1:0] yc,
  input  logic [COORD_W-1:0] r,
  output logic               in_o
);

  // One spare bit over the 2*COORD_W+1 needed keeps every term non-negative as signed.
  localparam int SQ_W = 2 * COORD_W + 2;

  logic signed [SQ_W-1:0] dx;
  logic signed [SQ_W-1:0] dy;
  logic signed [SQ_W-1:0] re;
  logic signed [SQ_W-1:0] dist_sq;
  logic signed [SQ_W-1:0] rad_sq;

  assign dx      = $signed(SQ_W'(x)) - $signed(SQ_W'(xc));
  assign dy      = $signed(SQ_W'(y)) - $signed(SQ_W'(yc));
  assign re      = $signed(SQ_W'(r));
  assign dist_sq = dx * dx + dy * dy;
  assign rad_sq  = re * re;
  assign in_o    = (dist_sq <= rad_sq);

endmodule

// File: rtl/set_scan.sv
// Scans the GRID_N x GRID_N lattice against three latched circles and counts hits
// returned by the logic unit. Define SET_SCAN_DBG_EN for coordinate/count debug ports.
module set_scan
  import set_scan_pkg::*;
#(
  parameter int GRID_N  = 8,
  parameter int COORD_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [6*COORD_W-1:0]   central,
  input  logic [3*COORD_W-1:0]   radius,
  input  logic [MODE_SZ-1:0]     mode,
  output logic [COVERED_SZ-1:0]  covered_o,
  output logic [MODE_SZ-1:0]     mode_o,
  output logic                   pt_valid_o,
  input  logic                   hit_i,
  output logic                   busy,
  output logic                   valid,
  output logic [CNT_W-1:0]       candidate
`ifdef SET_SCAN_DBG_EN
  ,
  output logic [COORD_W-1:0]     dbg_x_o,
  output logic [COORD_W-1:0]     dbg_y_o,
  output logic [CNT_W-1:0]       dbg_hit_cnt_o
`endif
);

  localparam int NPTS  = GRID_N * GRID_N;
  localparam int IDX_W = $clog2(NPTS);

  scan_state_t             state;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        cnt_next;
  logic [6*COORD_W-1:0]    cen_q;
  logic [3*COORD_W-1:0]    rad_q;
  logic [COORD_W-1:0]      pt_x;
  logic [COORD_W-1:0]      pt_y;
  logic [COVERED_SZ-1:0]   cov;

  assign pt_x = COORD_W'(int'(idx) % GRID_N + 1);
  assign pt_y = COORD_W'(int'(idx) / GRID_N + 1);

  set_cover #(.COORD_W(COORD_W)) u_cover_a (
    .x(pt_x), .y(pt_y),
    .xc(cen_q[CEN_AX*COORD_W +: COORD_W]), .yc(cen_q[CEN_AY*COORD_W +: COORD_W]),
    .r(rad_q[RAD_A*COORD_W +: COORD_W]), .in_o(cov[2])
  );

  set_cover #(.COORD_W(COORD_W)) u_cover_b (
    .x(pt_x), .y(pt_y),
    .xc(cen_q[CEN_BX*COORD_W +: COORD_W]), .yc(cen_q[CEN_BY*COORD_W +: COORD_W]),
    .r(rad_q[RAD_B*COORD_W +: COORD_W]), .in_o(cov[1])
  );

  set_cover #(.COORD_W(COORD_W)) u_cover_c (
    .x(pt_x), .y(pt_y),
    .xc(cen_q[CEN_CX*COORD_W +: COORD_W]), .yc(cen_q[CEN_CY*COORD_W +: COORD_W]),
    .r(rad_q[RAD_C*COORD_W +: COORD_W]), .in_o(cov[0])
  );

  // hit_i always refers to the point already on covered_o, so counting lags the scan by one.
  assign cnt_next = (hit_i && (count != {CNT_W{1'b1}})) ? count + CNT_W'(1) : count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN_IDLE;
      idx        <= '0;
      count      <= '0;
      cen_q      <= '0;
      rad_q      <= '0;
      covered_o  <= '0;
      mode_o     <= '0;
      pt_valid_o <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      candidate  <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        SCAN_IDLE, SCAN_DONE: begin
          if (en) begin
            cen_q  <= central;
            rad_q  <= radius;
            mode_o <= mode;
            count  <= '0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= SCAN_RUN;
          end else begin
            state <= SCAN_IDLE;
          end
        end
        SCAN_RUN: begin
          covered_o  <= cov;
          pt_valid_o <= 1'b1;
          if (pt_valid_o) count <= cnt_next;
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(NPTS - 1)) state <= SCAN_DRAIN;
        end
        SCAN_DRAIN: begin
          count      <= cnt_next;
          candidate  <= cnt_next;
          valid      <= 1'b1;
          busy       <= 1'b0;
          pt_valid_o <= 1'b0;
          covered_o  <= '0;
          state      <= SCAN_DONE;
        end
        default: state <= SCAN_IDLE;
      endcase
    end
  end

`ifdef SET_SCAN_DBG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_x_o <= '0;
      dbg_y_o <= '0;
    end else if (state == SCAN_RUN) begin
      dbg_x_o <= pt_x;
      dbg_y_o <= pt_y;
    end
  end

  assign dbg_hit_cnt_o = count;
`endif

endmodule
